// File: rtl/cpu_pkg.sv
// Shared definitions for the CHARIS-subset multicycle control path:
// opcodes, ALU and immediate-extension codes, FSM state and instruction classes.
package cpu_pkg;

    localparam int ALU_W = 4;
    localparam int IMM_W = 2;

    localparam logic [5:0] OP_RTYPE = 6'b100000;
    localparam logic [5:0] OP_LI    = 6'b111000;
    localparam logic [5:0] OP_LUI   = 6'b111001;
    localparam logic [5:0] OP_ADDI  = 6'b110000;
    localparam logic [5:0] OP_ANDI  = 6'b110010;
    localparam logic [5:0] OP_ORI   = 6'b110011;
    localparam logic [5:0] OP_B     = 6'b111111;
    localparam logic [5:0] OP_BEQ   = 6'b000000;
    localparam logic [5:0] OP_BNE   = 6'b000001;
    localparam logic [5:0] OP_LB    = 6'b000011;
    localparam logic [5:0] OP_LW    = 6'b001111;
    localparam logic [5:0] OP_SB    = 6'b000111;
    localparam logic [5:0] OP_SW    = 6'b011111;

    localparam logic [ALU_W-1:0] ALU_ADD = 4'b0000;
    localparam logic [ALU_W-1:0] ALU_SUB = 4'b0001;
    localparam logic [ALU_W-1:0] ALU_AND = 4'b0010;
    localparam logic [ALU_W-1:0] ALU_OR  = 4'b0011;
    localparam logic [ALU_W-1:0] ALU_NOT = 4'b0100;
    localparam logic [ALU_W-1:0] ALU_SRA = 4'b1000;
    localparam logic [ALU_W-1:0] ALU_SRL = 4'b1001;
    localparam logic [ALU_W-1:0] ALU_SLL = 4'b1010;
    localparam logic [ALU_W-1:0] ALU_ROL = 4'b1100;
    localparam logic [ALU_W-1:0] ALU_ROR = 4'b1101;

    localparam logic [IMM_W-1:0] IMM_SIGN     = 2'b00;
    localparam logic [IMM_W-1:0] IMM_ZERO     = 2'b01;
    localparam logic [IMM_W-1:0] IMM_HI16     = 2'b10;
    localparam logic [IMM_W-1:0] IMM_SIGN_SH2 = 2'b11;

    typedef enum logic [9:0] {
        S_FETCH    = 10'b0000000001,
        S_DECODE   = 10'b0000000010,
        S_EXEC_R   = 10'b0000000100,
        S_EXEC_I   = 10'b0000001000,
        S_WB_ALU   = 10'b0000010000,
        S_MEM_ADDR = 10'b0000100000,
        S_MEM_RD   = 10'b0001000000,
        S_WB_MEM   = 10'b0010000000,
        S_MEM_WR   = 10'b0100000000,
        S_BRANCH   = 10'b1000000000
    } state_t;

    typedef enum logic [2:0] {
        CLS_RTYPE,
        CLS_ITYPE,
        CLS_LOAD,
        CLS_STORE,
        CLS_BRANCH,
        CLS_ILLEGAL
    } instr_class_t;

    typedef enum logic [1:0] {
        BR_ALWAYS,
        BR_EQ,
        BR_NE
    } br_kind_t;

endpackage

// File: rtl/ctrl_opdecode.sv
// Combinational opcode lookup: instruction class, I-type ALU function,
// immediate-extension mode, byte-access flag and branch condition kind.
module ctrl_opdecode
    import cpu_pkg::*;
(
    input  logic [5:0]       i_opcode,
    output instr_class_t     o_class,
    output logic [ALU_W-1:0] o_aluFunc,
    output logic [IMM_W-1:0] o_immMode,
    output logic             o_byteOp,
    output br_kind_t         o_brKind
);

    always_comb begin
        o_class   = CLS_ILLEGAL;
        o_aluFunc = ALU_ADD;
        o_immMode = IMM_SIGN;
        o_byteOp  = 1'b0;
        o_brKind  = BR_ALWAYS;
        case (i_opcode)
            OP_RTYPE: o_class = CLS_RTYPE;
            OP_LI:    o_class = CLS_ITYPE;
            OP_LUI: begin
                o_class   = CLS_ITYPE;
                o_immMode = IMM_HI16;
            end
            OP_ADDI:  o_class = CLS_ITYPE;
            OP_ANDI: begin
                o_class   = CLS_ITYPE;
                o_aluFunc = ALU_AND;
                o_immMode = IMM_ZERO;
            end
            OP_ORI: begin
                o_class   = CLS_ITYPE;
                o_aluFunc = ALU_OR;
                o_immMode = IMM_ZERO;
            end
            OP_B: begin
                o_class   = CLS_BRANCH;
                o_immMode = IMM_SIGN_SH2;
            end
            OP_BEQ: begin
                o_class   = CLS_BRANCH;
                o_immMode = IMM_SIGN_SH2;
                o_brKind  = BR_EQ;
            end
            OP_BNE: begin
                o_class   = CLS_BRANCH;
                o_immMode = IMM_SIGN_SH2;
                o_brKind  = BR_NE;
            end
            OP_LB: begin
                o_class  = CLS_LOAD;
                o_byteOp = 1'b1;
            end
            OP_LW:    o_class = CLS_LOAD;
            OP_SB: begin
                o_class  = CLS_STORE;
                o_byteOp = 1'b1;
            end
            OP_SW:    o_class = CLS_STORE;
            default:  o_class = CLS_ILLEGAL;
        endcase
    end

endmodule

// File: rtl/multicycle_control.sv
// Multicycle control FSM: steps each instruction through fetch, decode,
// execute/memory and write-back, driving every datapath strobe.
module multicycle_control
    import cpu_pkg::*;
#(
    parameter int ALU_FUNC_W = 4,
    parameter int IMM_MODE_W = 2
) (
    input  logic                  Clk,
    input  logic                  Reset_n,
    input  logic [31:0]           Instr,
    input  logic                  ALU_zero,
    output logic                  PC_LdEn,
    output logic                  PC_sel,
    output logic                  IR_LdEn,
    output logic                  RF_WrEn,
    output logic                  RF_WrData_sel,
    output logic                  RF_B_sel,
    output logic [IMM_MODE_W-1:0] ImmExt_sel,
    output logic                  ALU_Bin_sel,
    output logic [ALU_FUNC_W-1:0] ALU_func,
    output logic                  MEM_WrEn,
    output logic                  ByteOp,
    output logic                  Illegal
);

    state_t           r_state;
    state_t           w_nextState;
    logic [5:0]       r_opcode;
    logic [3:0]       r_func;
    logic [5:0]       w_opcode;
    instr_class_t     w_class;
    logic [ALU_W-1:0] w_decAluFunc;
    logic [IMM_W-1:0] w_decImm;
    logic             w_decByte;
    br_kind_t         w_decBr;

    logic             w_pcLdEn;
    logic             w_pcSel;
    logic             w_irLdEn;
    logic             w_rfWrEn;
    logic             w_rfWdSel;
    logic             w_rfBSel;
    logic [IMM_W-1:0] w_immSel;
    logic             w_binSel;
    logic [ALU_W-1:0] w_aluFunc;
    logic             w_memWrEn;
    logic             w_byteOp;
    logic             w_illegal;
    logic             w_unusedInstr;

    assign w_unusedInstr = ^Instr[25:4];

    // IR was loaded at the end of FETCH, so during DECODE it is stable; later
    // states rely only on the copy captured in DECODE.
    assign w_opcode = (r_state == S_DECODE) ? Instr[31:26] : r_opcode;

    ctrl_opdecode u_opdecode (
        .i_opcode  (w_opcode),
        .o_class   (w_class),
        .o_aluFunc (w_decAluFunc),
        .o_immMode (w_decImm),
        .o_byteOp  (w_decByte),
        .o_brKind  (w_decBr)
    );

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_state  <= S_FETCH;
            r_opcode <= '0;
            r_func   <= '0;
        end else begin
            r_state <= w_nextState;
            if (r_state == S_DECODE) begin
                r_opcode <= Instr[31:26];
                r_func   <= Instr[3:0];
            end
        end
    end

    always_comb begin
        w_nextState = S_FETCH;
        w_pcLdEn    = 1'b0;
        w_pcSel     = 1'b0;
        w_irLdEn    = 1'b0;
        w_rfWrEn    = 1'b0;
        w_rfWdSel   = 1'b0;
        w_rfBSel    = 1'b0;
        w_immSel    = IMM_SIGN;
        w_binSel    = 1'b0;
        w_aluFunc   = ALU_ADD;
        w_memWrEn   = 1'b0;
        w_byteOp    = 1'b0;
        w_illegal   = 1'b0;
        case (r_state)
            S_FETCH: begin
                w_irLdEn    = 1'b1;
                w_nextState = S_DECODE;
            end
            S_DECODE: begin
                w_rfBSel = (w_class != CLS_RTYPE);
                w_immSel = w_decImm;
                case (w_class)
                    CLS_RTYPE:           w_nextState = S_EXEC_R;
                    CLS_ITYPE:           w_nextState = S_EXEC_I;
                    CLS_LOAD, CLS_STORE: w_nextState = S_MEM_ADDR;
                    CLS_BRANCH:          w_nextState = S_BRANCH;
                    default: begin
                        w_illegal   = 1'b1;
                        w_pcLdEn    = 1'b1;
                        w_nextState = S_FETCH;
                    end
                endcase
            end
            S_EXEC_R: begin
                w_aluFunc   = r_func;
                w_nextState = S_WB_ALU;
            end
            S_EXEC_I: begin
                w_binSel    = 1'b1;
                w_aluFunc   = w_decAluFunc;
                w_immSel    = w_decImm;
                w_nextState = S_WB_ALU;
            end
            S_WB_ALU: begin
                w_rfWrEn = 1'b1;
                w_pcLdEn = 1'b1;
            end
            S_MEM_ADDR: begin
                w_binSel    = 1'b1;
                w_nextState = (w_class == CLS_LOAD) ? S_MEM_RD : S_MEM_WR;
            end
            S_MEM_RD: begin
                w_byteOp    = w_decByte;
                w_nextState = S_WB_MEM;
            end
            S_WB_MEM: begin
                w_rfWrEn  = 1'b1;
                w_rfWdSel = 1'b1;
                w_pcLdEn  = 1'b1;
            end
            S_MEM_WR: begin
                w_memWrEn = 1'b1;
                w_rfBSel  = 1'b1;
                w_byteOp  = w_decByte;
                w_pcLdEn  = 1'b1;
            end
            S_BRANCH: begin
                w_aluFunc = ALU_SUB;
                w_rfBSel  = 1'b1;
                w_immSel  = IMM_SIGN_SH2;
                w_pcLdEn  = 1'b1;
                case (w_decBr)
                    BR_ALWAYS: w_pcSel = 1'b1;
                    BR_EQ:     w_pcSel = ALU_zero;
                    BR_NE:     w_pcSel = ~ALU_zero;
                    default:   w_pcSel = 1'b0;
                endcase
            end
            default: w_nextState = S_FETCH;
        endcase
    end

    // Outputs are forced low while reset is held so an aborted write never leaks.
    assign PC_LdEn       = Reset_n & w_pcLdEn;
    assign PC_sel        = Reset_n & w_pcSel;
    assign IR_LdEn       = Reset_n & w_irLdEn;
    assign RF_WrEn       = Reset_n & w_rfWrEn;
    assign RF_WrData_sel = Reset_n & w_rfWdSel;
    assign RF_B_sel      = Reset_n & w_rfBSel;
    assign ImmExt_sel    = Reset_n ? IMM_MODE_W'(w_immSel) : '0;
    assign ALU_Bin_sel   = Reset_n & w_binSel;
    assign ALU_func      = Reset_n ? ALU_FUNC_W'(w_aluFunc) : '0;
    assign MEM_WrEn      = Reset_n & w_memWrEn;
    assign ByteOp        = Reset_n & w_byteOp;
    assign Illegal       = Reset_n & w_illegal;

endmodule

// File: tb/tb_multicycle_control.sv
// Self-checking bench for multicycle_control: per-instruction expected strobe
// sequences built from the instruction-class rules, directed plus random stimulus.
module tb_multicycle_control;

    typedef struct packed {
        logic       pcLd;
        logic       pcSel;
        logic       irLd;
        logic       rfWr;
        logic       rfWdSel;
        logic       rfBSel;
        logic [1:0] imm;
        logic       binSel;
        logic [3:0] func;
        logic       memWr;
        logic       byteOp;
        logic       illegal;
    } outs_t;

    logic        Clk;
    logic        Reset_n;
    logic [31:0] Instr;
    logic        ALU_zero;
    logic        PC_LdEn, PC_sel, IR_LdEn, RF_WrEn, RF_WrData_sel, RF_B_sel;
    logic [1:0]  ImmExt_sel;
    logic        ALU_Bin_sel;
    logic [3:0]  ALU_func;
    logic        MEM_WrEn, ByteOp, Illegal;
    outs_t       obs;

    int          checkCount = 0;
    int          errorCount = 0;
    outs_t       expQ[$];

    multicycle_control #(.ALU_FUNC_W(4), .IMM_MODE_W(2)) dut (
        .Clk           (Clk),
        .Reset_n       (Reset_n),
        .Instr         (Instr),
        .ALU_zero      (ALU_zero),
        .PC_LdEn       (PC_LdEn),
        .PC_sel        (PC_sel),
        .IR_LdEn       (IR_LdEn),
        .RF_WrEn       (RF_WrEn),
        .RF_WrData_sel (RF_WrData_sel),
        .RF_B_sel      (RF_B_sel),
        .ImmExt_sel    (ImmExt_sel),
        .ALU_Bin_sel   (ALU_Bin_sel),
        .ALU_func      (ALU_func),
        .MEM_WrEn      (MEM_WrEn),
        .ByteOp        (ByteOp),
        .Illegal       (Illegal)
    );

    assign obs = {PC_LdEn, PC_sel, IR_LdEn, RF_WrEn, RF_WrData_sel, RF_B_sel,
                  ImmExt_sel, ALU_Bin_sel, ALU_func, MEM_WrEn, ByteOp, Illegal};

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    // Expected strobes for every cycle of one instruction, straight from the class rules.
    task automatic buildExpected(input logic [31:0] instr, input logic zero);
        outs_t      o;
        logic [5:0] op;
        string      kind;
        logic [1:0] imm;
        logic [3:0] iFunc;
        logic       isByte;
        logic       taken;
        op     = instr[31:26];
        imm    = 2'b00;
        iFunc  = 4'b0000;
        isByte = 1'b0;
        taken  = 1'b0;
        case (op)
            6'b100000: kind = "R";
            6'b111000: kind = "I";
            6'b111001: begin kind = "I"; imm = 2'b10; end
            6'b110000: kind = "I";
            6'b110010: begin kind = "I"; imm = 2'b01; iFunc = 4'b0010; end
            6'b110011: begin kind = "I"; imm = 2'b01; iFunc = 4'b0011; end
            6'b111111: begin kind = "BR"; imm = 2'b11; taken = 1'b1; end
            6'b000000: begin kind = "BR"; imm = 2'b11; taken = zero; end
            6'b000001: begin kind = "BR"; imm = 2'b11; taken = !zero; end
            6'b000011: begin kind = "LD"; isByte = 1'b1; end
            6'b001111: kind = "LD";
            6'b000111: begin kind = "ST"; isByte = 1'b1; end
            6'b011111: kind = "ST";
            default:   kind = "ILL";
        endcase
        expQ.delete();
        o = '0; o.irLd = 1'b1; expQ.push_back(o);
        o = '0; o.rfBSel = (kind != "R"); o.imm = imm;
        if (kind == "ILL") begin
            o.illegal = 1'b1;
            o.pcLd    = 1'b1;
        end
        expQ.push_back(o);
        if (kind == "R") begin
            o = '0; o.func = instr[3:0]; expQ.push_back(o);
            o = '0; o.rfWr = 1'b1; o.pcLd = 1'b1; expQ.push_back(o);
        end else if (kind == "I") begin
            o = '0; o.binSel = 1'b1; o.func = iFunc; o.imm = imm; expQ.push_back(o);
            o = '0; o.rfWr = 1'b1; o.pcLd = 1'b1; expQ.push_back(o);
        end else if (kind == "LD" || kind == "ST") begin
            o = '0; o.binSel = 1'b1; expQ.push_back(o);
            if (kind == "LD") begin
                o = '0; o.byteOp = isByte; expQ.push_back(o);
                o = '0; o.rfWr = 1'b1; o.rfWdSel = 1'b1; o.pcLd = 1'b1; expQ.push_back(o);
            end else begin
                o = '0; o.memWr = 1'b1; o.rfBSel = 1'b1; o.byteOp = isByte; o.pcLd = 1'b1;
                expQ.push_back(o);
            end
        end else if (kind == "BR") begin
            o = '0; o.func = 4'b0001; o.rfBSel = 1'b1; o.imm = 2'b11; o.pcLd = 1'b1;
            o.pcSel = taken;
            expQ.push_back(o);
        end
    endtask

    // Runs one instruction from its FETCH cycle; abortAt >= 0 asserts reset in that cycle.
    task automatic applyStimulus(input logic [31:0] instr, input logic zero, input string tag,
                                 input int abortAt);
        buildExpected(instr, zero);
        for (int i = 0; i < expQ.size(); i++) begin
            Instr    = (i == 1) ? instr : $urandom;
            ALU_zero = zero;
            @(negedge Clk);
            checkOutput($sformatf("%s.c%0d", tag, i), 32'(obs), 32'(expQ[i]));
            if (i == abortAt) begin
                #2 Reset_n = 1'b0;
                #1 checkOutput($sformatf("%s.abort", tag), 32'(obs), 32'd0);
                @(posedge Clk);
                #1 checkOutput($sformatf("%s.hold", tag), 32'(obs), 32'd0);
                Reset_n = 1'b1;
                return;
            end
            @(posedge Clk);
            #1;
        end
    endtask

    initial begin
        logic [5:0]  legalOps [13];
        logic [5:0]  op;
        logic [31:0] instr;
        legalOps = '{6'b100000, 6'b111000, 6'b111001, 6'b110000, 6'b110010, 6'b110011,
                     6'b111111, 6'b000000, 6'b000001, 6'b000011, 6'b001111, 6'b000111,
                     6'b011111};
        Reset_n  = 1'b0;
        Instr    = 32'h0;
        ALU_zero = 1'b0;
        repeat (2) begin
            @(negedge Clk);
            checkOutput("reset", 32'(obs), 32'd0);
        end
        @(posedge Clk);
        #1 Reset_n = 1'b1;

        applyStimulus(32'hE0218002, 1'b0, "li", -1);
        applyStimulus({6'b001111, 26'h0421234}, 1'b0, "lw", -1);
        applyStimulus({6'b000111, 26'h0430010}, 1'b1, "sb", -1);
        applyStimulus({6'b000000, 26'h0220004}, 1'b1, "beqZ1", -1);
        applyStimulus({6'b000000, 26'h0220004}, 1'b0, "beqZ0", -1);
        applyStimulus({6'b000001, 26'h0220004}, 1'b1, "bneZ1", -1);
        applyStimulus({6'b000001, 26'h0220004}, 1'b0, "bneZ0", -1);
        applyStimulus({6'b111111, 26'h3FFFFFC}, 1'b0, "b", -1);
        applyStimulus({6'b010101, 26'h1234567}, 1'b0, "illegal", -1);
        applyStimulus({6'b100000, 26'h0221800}, 1'b0, "addAbort", 3);
        applyStimulus({6'b000011, 26'h0410008}, 1'b0, "lb", -1);
        applyStimulus({6'b011111, 26'h0410008}, 1'b0, "sw", -1);
        applyStimulus({6'b100000, 26'h0221801}, 1'b0, "sub", -1);
        applyStimulus({6'b110011, 26'h041FFFF}, 1'b0, "ori", -1);
        applyStimulus({6'b110010, 26'h0418000}, 1'b0, "andi", -1);
        applyStimulus({6'b111001, 26'h001ABCD}, 1'b0, "lui", -1);
        applyStimulus({6'b110000, 26'h041FFF0}, 1'b0, "addi", -1);

        for (int n = 0; n < 300; n++) begin
            if ($urandom_range(0, 7) == 0) op = 6'($urandom);
            else op = legalOps[$urandom_range(0, 12)];
            instr = {op, 26'($urandom)};
            applyStimulus(instr, 1'($urandom), $sformatf("rnd%0d", n),
                          ($urandom_range(0, 39) == 0) ? $urandom_range(0, 2) : -1);
        end

        $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
        $finish;
    end

endmodule

// File: doc/multicycle_control.md
Name: multicycle_control

Overview:
- Multicycle control FSM for the CHARIS-subset datapath.
- Consumes the instruction register contents and the ALU Zero flag.
- Produces every datapath strobe: PC, IR, RF write-back (RF_WrEn, RF_WrData_sel, RF_B_sel), immediate mode, ALU operand/function, and memory write.
- Sits beside FETCH/DECODE/EXEC/MEM; it is the producer of the control inputs that DECODE consumes.

Parameters:
- ALU_FUNC_W, 4, width of ALU_func bus.
- IMM_MODE_W, 2, width of ImmExt_sel bus.

Ports:
- Clk  in  1  rising-edge clock.
- Reset_n  in  1  asynchronous, active-low reset.
- Instr  in  32  current IR contents; opcode [31:26], func [3:0].
- ALU_zero  in  1  ALU Zero flag from EXEC.
- PC_LdEn  out  1  PC load enable.
- PC_sel  out  1  0 = PC+4, 1 = PC+4+(Immed<<2).
- IR_LdEn  out  1  latch MEM instruction word into IR.
- RF_WrEn  out  1  register file write enable.
- RF_WrData_sel  out  1  0 = ALU_out, 1 = MEM_out.
- RF_B_sel  out  1  0 = read Instr[15:11], 1 = read Instr[20:16].
- ImmExt_sel  out  2  00 sign-ext, 01 zero-ext, 10 shift-left-16, 11 sign-ext<<2.
- ALU_Bin_sel  out  1  0 = RF_B, 1 = Immed.
- ALU_func  out  4  ALU operation.
- MEM_WrEn  out  1  data memory write.
- ByteOp  out  1  byte access for lb/sb.
- Illegal  out  1  one-cycle pulse on unknown opcode.

Behaviour:
- Reset (async, Reset_n=0):
  - state=S_FETCH; all outputs 0.
  - Mid-instruction reset aborts immediately; no RF/MEM/PC write may occur in the reset cycle or afterward until a new S_FETCH completes.
- All outputs are Moore: decoded from state plus registered opcode/func, never from raw Instr in the same cycle as IR load.
- Opcode and func are captured into internal registers in S_DECODE.
- Opcode map:
  - 100000 R-type (func 0000 add, 0001 sub, 0010 and, 0011 or, 0100 not, 1000 sra, 1001 srl, 1010 sll, 1100 rol, 1101 ror).
  - 111000 li, 111001 lui, 110000 addi, 110010 andi, 110011 ori.
  - 111111 b, 000000 beq, 000001 bne.
  - 000011 lb, 001111 lw, 000111 sb, 011111 sw.
- State sequence and active outputs:
  - S_FETCH: IR_LdEn=1 → S_DECODE.
  - S_DECODE: RF_B_sel=1 except R-type (0); ImmExt_sel set per opcode. Next state by opcode:
    - R → S_EXEC_R
    - li/lui/addi/andi/ori → S_EXEC_I
    - loads/stores → S_MEM_ADDR
    - branches → S_BRANCH
    - unknown → S_FETCH with Illegal=1 and PC_LdEn=1, PC_sel=0 (skip).
  - S_EXEC_R: ALU_Bin_sel=0, ALU_func=func → S_WB_ALU.
  - S_EXEC_I: ALU_Bin_sel=1; ALU_func add (li, lui, addi), and (andi), or (ori); li/lui use RS forced to r0 by datapath → S_WB_ALU.
  - S_WB_ALU: RF_WrEn=1, RF_WrData_sel=0, PC_LdEn=1, PC_sel=0 → S_FETCH.
  - S_MEM_ADDR: ALU_Bin_sel=1, ALU_func=add, ImmExt_sel=00 → S_MEM_RD (loads) or S_MEM_WR (stores).
  - S_MEM_RD: ByteOp per opcode → S_WB_MEM.
  - S_WB_MEM: RF_WrEn=1, RF_WrData_sel=1, PC_LdEn=1, PC_sel=0 → S_FETCH.
  - S_MEM_WR: MEM_WrEn=1 for exactly one cycle, RF_B_sel=1, ByteOp per opcode, PC_LdEn=1, PC_sel=0 → S_FETCH.
  - S_BRANCH: ALU_func=sub, ALU_Bin_sel=0, RF_B_sel=1, ImmExt_sel=11, PC_LdEn=1. PC_sel=1 if b, or beq with ALU_zero=1, or bne with ALU_zero=0; else 0 → S_FETCH.
- Latency in cycles: R/I = 4; load = 5; store = 4; branch = 3; illegal = 2.
- Invariants:
  - Exactly one PC_LdEn pulse per instruction.
  - RF_WrEn and MEM_WrEn are never high in the same cycle.
  - IR_LdEn is high only in S_FETCH.
- Writes to r0 are not filtered here; the register file ignores them.

Decomposition:
- Shared package cpu_pkg holds:
  - opcode localparams (OP_RTYPE, OP_LI, …);
  - ALU function codes;
  - ImmExt mode codes;
  - state encoding (one-hot, 10 states).
- One sub-module, ctrl_opdecode (combinational opcode → instruction-class / ALU-func / imm-mode lookup), is instantiated by multicycle_control.

Test Plan:
- Reset_n low mid-S_WB_ALU with Instr=add → RF_WrEn drops to 0 the same instant; state S_FETCH; all outputs 0.
- Instr=0xE0218002 (li r1) → IR_LdEn cycle 1; ImmExt_sel=00 and RF_B_sel=1 cycle 2; ALU_Bin_sel=1, ALU_func=add cycle 3; RF_WrEn=1, RF_WrData_sel=0, PC_LdEn=1 cycle 4.
- Instr=lw (opcode 001111) → RF_WrEn=1 with RF_WrData_sel=1 in cycle 5 only; MEM_WrEn never 1.
- Instr=sb (opcode 000111) → MEM_WrEn=1 and ByteOp=1 in cycle 4 for one cycle; RF_WrEn stays 0.
- beq with ALU_zero=1 → PC_sel=1 in cycle 3; same instruction with ALU_zero=0 → PC_sel=0; bne gives the inverse results.
- Opcode 010101 → Illegal pulses one cycle in cycle 2 with PC_LdEn=1, PC_sel=0; next cycle IR_LdEn=1.
